// File: rtl/memwb_pipe_reg_pkg.sv
// Shared types for the MEM/WB pipeline register: default field widths, entry-count
// state encoding and the packed entry layout.
package memwb_pipe_reg_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_TWO   = TWO
  } stateT;

  typedef struct packed {
    logic                  regWrite;
    logic                  memToReg;
    logic [DATA_W_DEF-1:0] readData;
    logic [DATA_W_DEF-1:0] aluResult;
    logic [REG_AW_DEF-1:0] writeReg;
  } memwbEntryT;

endpackage

// File: rtl/memwb_pipe_reg_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, cache-hit capture gate, flush,
// miss-stall counter and pre-muxed writeback data. Define MEMWB_SKID_EN for the
// two-entry skid buffer with a registered in_ready; otherwise a single entry is held.
module memwb_pipe_reg
  import memwb_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hit,
  input  logic              flush,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] write_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_AW-1:0] write_reg_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              regWrite;
    logic              memToReg;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] aluResult;
    logic [REG_AW-1:0] writeReg;
  } entryT;

  entryT inEntry, headQ, headD;
  stateT stateQ, stateD;
  logic  push, pop;

  assign inEntry = {reg_write_in, mem_to_reg_in, read_data_in, alu_result_in, write_reg_in};

  assign out_valid = (stateQ != ST_EMPTY);
  assign push      = in_valid & hit & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Gating with out_valid keeps a stale head from ever reaching the register file.
  assign reg_write_out  = headQ.regWrite & out_valid;
  assign mem_to_reg_out = headQ.memToReg;
  assign read_data_out  = headQ.readData;
  assign alu_result_out = headQ.aluResult;
  assign write_reg_out  = headQ.writeReg;
  assign wb_data_out    = headQ.memToReg ? headQ.readData : headQ.aluResult;

`ifdef MEMWB_SKID_EN
  entryT tailQ, tailD;
  logic  inReadyQ;

  // A lone head that is back-pressured stays put; the new entry parks in the tail.
  always_comb begin
    stateD = stateQ;
    headD  = headQ;
    tailD  = tailQ;
    if (flush) begin
      stateD = ST_EMPTY;
    end else begin
      case (stateQ)
        ST_EMPTY: begin
          if (push) begin
            headD  = inEntry;
            stateD = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            headD = inEntry;
          end else if (push) begin
            tailD  = inEntry;
            stateD = ST_TWO;
          end else if (pop) begin
            stateD = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            headD  = tailQ;
            stateD = ST_ONE;
          end
        end
        default: stateD = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tailQ    <= '0;
      inReadyQ <= 1'b1;
    end else begin
      tailQ    <= tailD;
      inReadyQ <= (stateD != ST_TWO);
    end
  end

  assign in_ready = inReadyQ;
`else
  always_comb begin
    stateD = stateQ;
    headD  = headQ;
    if (flush) begin
      stateD = ST_EMPTY;
    end else begin
      case (stateQ)
        ST_EMPTY: begin
          if (push) begin
            headD  = inEntry;
            stateD = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push) begin
            headD = inEntry;
          end else if (pop) begin
            stateD = ST_EMPTY;
          end
        end
        default: stateD = ST_EMPTY;
      endcase
    end
  end

  assign in_ready = ~out_valid | out_ready;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= ST_EMPTY;
      headQ  <= '0;
    end else begin
      stateQ <= stateD;
      headQ  <= headD;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) stallCounter (
    .clk  (clk),
    .rst  (rst),
    .inc  (in_valid & ~hit),
    .count(stall_count)
  );

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Self-checking bench for memwb_pipe_reg: directed table, hand sequences for the
// multi-cycle corners, then random traffic against a queue-based reference model.
module tb_memwb_pipe_reg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 4;
  localparam int CAP    =
`ifdef MEMWB_SKID_EN
    2;
`else
    1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, hit, flush;
  logic              reg_write_in, mem_to_reg_in;
  logic [DATA_W-1:0] read_data_in, alu_result_in;
  logic [REG_AW-1:0] write_reg_in;
  logic              out_valid, out_ready, reg_write_out, mem_to_reg_out;
  logic [DATA_W-1:0] read_data_out, alu_result_out, wb_data_out;
  logic [REG_AW-1:0] write_reg_out;
  logic [CNT_W-1:0]  stall_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic              inValid, hit, flush, outReady, regWrite, memToReg;
    logic [DATA_W-1:0] readData, aluResult;
    logic [REG_AW-1:0] writeReg;
    logic              expValid, expRegWrite;
    logic [DATA_W-1:0] expWb;
    logic              expReady;
    logic [CNT_W-1:0]  expStall;
  } vecT;

  typedef struct {
    logic              rw, m2r;
    logic [DATA_W-1:0] rd, alu;
    logic [REG_AW-1:0] wr;
  } entT;

  entT mQ[$];
  int  mStall = 0;

  memwb_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .hit(hit),
    .flush(flush), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .wb_data_out(wb_data_out), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic h, input logic fl, input logic orr,
                               input logic rw, input logic m2r, input logic [DATA_W-1:0] rd,
                               input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] wr);
    in_valid      = iv;
    hit           = h;
    flush         = fl;
    out_ready     = orr;
    reg_write_in  = rw;
    mem_to_reg_in = m2r;
    read_data_in  = rd;
    alu_result_in = alu;
    write_reg_in  = wr;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic erw,
                             input logic [DATA_W-1:0] ewb, input logic er, input logic chkWb);
    compare({name, ".out_valid"}, 32'(out_valid), 32'(ev));
    compare({name, ".reg_write_out"}, 32'(reg_write_out), 32'(erw));
    compare({name, ".in_ready"}, 32'(in_ready), 32'(er));
    if (chkWb) compare({name, ".wb_data_out"}, 32'(wb_data_out), 32'(ewb));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vecT mkVec(input logic iv, input logic h, input logic fl, input logic orr,
                                input logic rw, input logic m2r, input logic [DATA_W-1:0] rd,
                                input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] wr,
                                input logic ev, input logic erw, input logic [DATA_W-1:0] ewb,
                                input logic er, input logic [CNT_W-1:0] es);
    vecT v;
    v.inValid = iv; v.hit = h; v.flush = fl; v.outReady = orr;
    v.regWrite = rw; v.memToReg = m2r; v.readData = rd; v.aluResult = alu; v.writeReg = wr;
    v.expValid = ev; v.expRegWrite = erw; v.expWb = ewb; v.expReady = er; v.expStall = es;
    return v;
  endfunction

  // Reference model: a FIFO of capacity CAP, a flush that empties it and a capped miss count.
  function automatic logic modelInReady(input logic orr);
    if (CAP == 2) return (mQ.size() < 2);
    return (mQ.size() == 0) || orr;
  endfunction

  task automatic randomCycle(input logic iv, input logic h, input logic fl, input logic orr);
    entT e;
    logic doPush, doPop;
    e.rw = 1'($urandom); e.m2r = 1'($urandom);
    e.rd = DATA_W'($urandom); e.alu = DATA_W'($urandom); e.wr = REG_AW'($urandom);
    applyStimulus(iv, h, fl, orr, e.rw, e.m2r, e.rd, e.alu, e.wr);
    doPush = iv & h & modelInReady(orr) & ~fl;
    doPop  = (mQ.size() > 0) & orr;
    if (iv && !h && mStall < (1 << CNT_W) - 1) mStall++;
    step();
    if (fl) mQ.delete();
    else begin
      if (doPop) void'(mQ.pop_front());
      if (doPush) mQ.push_back(e);
    end
    compare("rnd.out_valid", 32'(out_valid), 32'(mQ.size() > 0));
    compare("rnd.in_ready", 32'(in_ready), 32'(modelInReady(orr)));
    compare("rnd.stall_count", 32'(stall_count), 32'(mStall));
    if (mQ.size() > 0) begin
      compare("rnd.reg_write_out", 32'(reg_write_out), 32'(mQ[0].rw));
      compare("rnd.write_reg_out", 32'(write_reg_out), 32'(mQ[0].wr));
      compare("rnd.read_data_out", 32'(read_data_out), 32'(mQ[0].rd));
      compare("rnd.alu_result_out", 32'(alu_result_out), 32'(mQ[0].alu));
      compare("rnd.wb_data_out", 32'(wb_data_out), 32'(mQ[0].m2r ? mQ[0].rd : mQ[0].alu));
    end else begin
      compare("rnd.reg_write_out", 32'(reg_write_out), 32'(0));
    end
  endtask

  initial begin
    vecT tbl[11];
    tbl[0]  = mkVec(1, 1, 0, 1, 1, 0, 16'hAAAA, 16'h1234, 3, 1, 1, 16'h1234, 1, 0);
    tbl[1]  = mkVec(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0);
    tbl[2]  = mkVec(1, 0, 0, 1, 1, 1, 16'h5555, 16'h6666, 1, 0, 0, 16'h0000, 1, 1);
    tbl[3]  = mkVec(1, 0, 0, 1, 1, 1, 16'h5555, 16'h6666, 1, 0, 0, 16'h0000, 1, 2);
    tbl[4]  = mkVec(1, 0, 0, 1, 1, 1, 16'h5555, 16'h6666, 1, 0, 0, 16'h0000, 1, 3);
    tbl[5]  = mkVec(1, 0, 0, 1, 1, 1, 16'h5555, 16'h6666, 1, 0, 0, 16'h0000, 1, 4);
    tbl[6]  = mkVec(1, 0, 0, 1, 1, 1, 16'h5555, 16'h6666, 1, 0, 0, 16'h0000, 1, 5);
    tbl[7]  = mkVec(1, 1, 0, 1, 1, 1, 16'hBEEF, 16'h0001, 5, 1, 1, 16'hBEEF, 1, 5);
    tbl[8]  = mkVec(1, 1, 0, 1, 0, 0, 16'h1111, 16'h0C0C, 6, 1, 0, 16'h0C0C, 1, 5);
    tbl[9]  = mkVec(1, 1, 1, 1, 1, 0, 16'h2222, 16'h0D0D, 7, 0, 0, 16'h0000, 1, 5);
    tbl[10] = mkVec(1, 0, 1, 1, 1, 0, 16'h2222, 16'h0D0D, 7, 0, 0, 16'h0000, 1, 6);

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, '0, '0, '0);
    #12;
    checkOutput("reset", 0, 0, '0, 1, 1);
    compare("reset.read_data_out", 32'(read_data_out), 32'(0));
    compare("reset.stall_count", 32'(stall_count), 32'(0));
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].inValid, tbl[i].hit, tbl[i].flush, tbl[i].outReady,
                    tbl[i].regWrite, tbl[i].memToReg, tbl[i].readData,
                    tbl[i].aluResult, tbl[i].writeReg);
      step();
      checkOutput($sformatf("tbl%0d", i), tbl[i].expValid, tbl[i].expRegWrite,
                  tbl[i].expWb, tbl[i].expReady, tbl[i].expValid);
      compare($sformatf("tbl%0d.stall_count", i), 32'(stall_count), 32'(tbl[i].expStall));
    end

    // Counter is at 6; eight more misses reach 14, four more must pin it at 15.
    applyStimulus(1, 0, 0, 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < 8; k++) step();
    compare("satNear.stall_count", 32'(stall_count), 32'(14));
    for (int k = 0; k < 4; k++) step();
    compare("satHold.stall_count", 32'(stall_count), 32'(15));

`ifdef MEMWB_SKID_EN
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h000A, 1); step();
    checkOutput("skidA", 1, 1, 16'h000A, 1, 1);
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h000B, 2); step();
    checkOutput("skidB", 1, 1, 16'h000A, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h000C, 3); step();
    checkOutput("skidCHeld", 1, 1, 16'h000A, 0, 1);
    applyStimulus(1, 1, 0, 1, 1, 0, '0, 16'h000C, 3); step();
    checkOutput("drainA", 1, 1, 16'h000B, 1, 1);
    step();
    checkOutput("acceptC", 1, 1, 16'h000C, 1, 1);
    applyStimulus(0, 1, 0, 1, 0, 0, '0, '0, '0); step();
    checkOutput("drainC", 0, 0, '0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h0011, 1); step();
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h0022, 2); step();
    checkOutput("fillTwo", 1, 1, 16'h0011, 0, 1);
`else
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h000A, 1); step();
    checkOutput("nsA", 1, 1, 16'h000A, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h000B, 2); step();
    checkOutput("nsBHeld", 1, 1, 16'h000A, 0, 1);
    applyStimulus(1, 1, 0, 1, 1, 0, '0, 16'h000B, 2); #1;
    compare("nsReadyComb.in_ready", 32'(in_ready), 32'(1));
    step();
    checkOutput("nsB", 1, 1, 16'h000B, 1, 1);
    applyStimulus(0, 1, 0, 1, 0, 0, '0, '0, '0); step();
    checkOutput("nsDrain", 0, 0, '0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, '0, 16'h0011, 1); step();
    checkOutput("nsFull", 1, 1, 16'h0011, 0, 1);
`endif
    applyStimulus(1, 1, 1, 0, 1, 0, '0, 16'h0033, 4); step();
    checkOutput("flushFull", 0, 0, '0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, '0, '0, '0); step();
    checkOutput("flushDrop", 0, 0, '0, 1, 0);

    applyStimulus(1, 1, 0, 0, 1, 1, 16'h7777, 16'h0077, 7); step();
    checkOutput("preRst", 1, 1, 16'h7777, CAP == 2, 1);
    #3 rst = 1'b1;
    #1;
    checkOutput("asyncRst", 0, 0, '0, 1, 1);
    compare("asyncRst.write_reg_out", 32'(write_reg_out), 32'(0));
    compare("asyncRst.stall_count", 32'(stall_count), 32'(0));
    step();
    rst = 1'b0;

    for (int i = 0; i < 40; i++) randomCycle(1, 1, 0, 1'(i % 2));
    for (int i = 0; i < 300; i++)
      randomCycle(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
